// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and helpers for the L1 miss-fill controller.
// 128 sets x 16-byte blocks of 16-bit words; byte address = {tag, index, offset, 1'b0}.
package cache_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int INDEX_W   = 7;
  localparam int WORDS     = 8;
  localparam int OFF_W     = 3;
  localparam int TAG_W     = ADDR_W - INDEX_W - 4;
  localparam int BASE_W    = ADDR_W - 4;

  localparam int OFF_LSB   = 1;
  localparam int INDEX_LSB = 4;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WRITE_TAG = 2'd2
  } state_e;

  function automatic logic [WORDS-1:0] word_onehot(input logic [OFF_W-1:0] idx);
    logic [WORDS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle between hit/miss compare, pipelined memory and the data/tag arrays.
// The slave side is the fill controller; the master side is its environment.
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic                 miss_detected;
  logic [ADDR_W-1:0]    miss_address;
  logic                 mem_data_valid;
  logic [DATA_W-1:0]    mem_data_in;

  logic                 fsm_busy;
  logic                 mem_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [INDEX_W-1:0]   fill_index;
  logic [WORDS-1:0]     fill_word_en;
  logic [DATA_W-1:0]    fill_data;
  logic                 write_data_array;
  logic                 write_tag_array;
  logic [TAG_W-1:0]     fill_tag;

  modport master (
    output miss_detected, miss_address, mem_data_valid, mem_data_in,
    input  fsm_busy, mem_en, mem_addr, fill_index, fill_word_en, fill_data,
           write_data_array, write_tag_array, fill_tag
  );

  modport slave (
    input  miss_detected, miss_address, mem_data_valid, mem_data_in,
    output fsm_busy, mem_en, mem_addr, fill_index, fill_word_en, fill_data,
           write_data_array, write_tag_array, fill_tag
  );

endinterface

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// 3-bit word counter with clear, enable and a sticky terminal flag.
// Saturates at the last word instead of wrapping so a fill can never re-issue word 0.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [OFF_W-1:0] cnt,
  output logic             done
);

  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (cnt_q == OFF_W'(WORDS - 1)) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches an 8-word block, writes each word as it returns,
// then writes tag/valid. Issue and return sides count independently so they may overlap.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.slave  bus
);

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                wr_vld_q, wr_vld_d;
  logic [OFF_W-1:0]    wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                accept_miss;
  logic                issue_clr, issue_en, issue_done;
  logic [OFF_W-1:0]    issue_cnt;
  logic                ret_clr, ret_take, ret_last, ret_done;
  logic [OFF_W-1:0]    ret_cnt;

  assign accept_miss = (state_q == IDLE) && bus.miss_detected;
  assign issue_clr   = (state_q != FILL);
  assign issue_en    = (state_q == FILL) && !issue_done;
  assign ret_clr     = (state_q != FILL);
  // Valids outside FILL are stray and must not touch the data array.
  assign ret_take    = (state_q == FILL) && bus.mem_data_valid && !ret_done;
  assign ret_last    = ret_take && (ret_cnt == OFF_W'(WORDS - 1));

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (issue_clr),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .done  (issue_done)
  );

  fill_word_counter u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ret_clr),
    .en    (ret_take),
    .cnt   (ret_cnt),
    .done  (ret_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.miss_detected) state_d = FILL;
      FILL:      if (ret_last)          state_d = WRITE_TAG;
      WRITE_TAG:                        state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Block base and the one-cycle-delayed data-array write slot.
  always_comb begin
    base_d    = base_q;
    wr_vld_d  = ret_take;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (accept_miss) begin
      base_d = bus.miss_address[ADDR_W-1:INDEX_LSB];
    end
    if (ret_take) begin
      wr_idx_d  = ret_cnt;
      wr_data_d = bus.mem_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      base_q    <= base_d;
      wr_vld_q  <= wr_vld_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    bus.fsm_busy         = (state_q != IDLE);
    bus.mem_en           = issue_en;
    bus.mem_addr         = issue_en ? {base_q, issue_cnt, {OFF_LSB{1'b0}}} : '0;
    bus.write_data_array = wr_vld_q;
    bus.fill_word_en     = wr_vld_q ? word_onehot(wr_idx_q) : '0;
    bus.fill_data        = wr_data_q;
    bus.write_tag_array  = (state_q == WRITE_TAG);
    bus.fill_index       = base_q[TAG_LSB-INDEX_LSB-1:0];
    bus.fill_tag         = base_q[BASE_W-1:TAG_LSB-INDEX_LSB];
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a latency/gap memory responder plus a
// transaction-level model checked every cycle, and literal timing pins for the model.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk;
  logic rst_n;
  cache_fill_fsm_if bus();

  cache_fill_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [15:0] addr; int due; } req_t;
  req_t req_q[$];

  int cyc = 0, errors = 0, checks = 0;
  int lat = 4, gap_max = 0, gap_left = 0, returns_sent = 0;
  int n_memen = 0, n_dataw = 0, n_tagw = 0;

  // model state
  bit          m_busy = 0, m_pw = 0;
  int          m_acc = 0, m_ret = 0, m_pw_idx = 0;
  logic [11:0] m_base = '0;

  logic        snap_busy [0:8191];
  logic        snap_memen[0:8191];
  logic        snap_tagw [0:8191];
  logic [15:0] snap_addr [0:8191];
  logic [7:0]  snap_wen  [0:8191];
  logic [6:0]  snap_idx  [0:8191];
  logic [4:0]  snap_tag  [0:8191];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the transaction model, sampled on the falling edge.
  initial begin
    int          k, s;
    bit          e_memen, e_tag;
    logic [7:0]  e_wen;
    forever begin
      @(negedge clk);
      s = cyc % 8192;
      snap_busy[s] = bus.fsm_busy;   snap_memen[s] = bus.mem_en;
      snap_tagw[s] = bus.write_tag_array; snap_addr[s] = bus.mem_addr;
      snap_wen[s]  = bus.fill_word_en; snap_idx[s] = bus.fill_index; snap_tag[s] = bus.fill_tag;
      if (!rst_n) begin
        chk("rst_ctrl", 32'({bus.fsm_busy, bus.mem_en, bus.write_data_array, bus.write_tag_array,
                             bus.fill_word_en, bus.fill_index, bus.fill_tag}), 32'd0);
        chk("rst_data", {bus.mem_addr, bus.fill_data}, 32'd0);
        m_busy = 0; m_pw = 0; m_ret = 0; m_base = '0;
      end else begin
        k       = cyc - m_acc;
        e_memen = m_busy && (k >= 1) && (k <= 8);
        e_tag   = m_pw && (m_pw_idx == 7);
        e_wen   = m_pw ? 8'(1 << m_pw_idx) : 8'h00;
        chk("busy",       32'(bus.fsm_busy), 32'(m_busy));
        chk("mem_en",     32'(bus.mem_en), 32'(e_memen));
        if (e_memen)
          chk("mem_addr", 32'(bus.mem_addr), 32'({m_base, 3'(k - 1), 1'b0}));
        chk("wr_data_arr", 32'(bus.write_data_array), 32'(m_pw));
        chk("word_en",    32'(bus.fill_word_en), 32'(e_wen));
        if (m_pw)
          chk("fill_data", 32'(bus.fill_data), 32'(mem_word({m_base, 3'(m_pw_idx), 1'b0})));
        chk("wr_tag_arr", 32'(bus.write_tag_array), 32'(e_tag));
        chk("fill_index", 32'(bus.fill_index), 32'(m_base[6:0]));
        chk("fill_tag",   32'(bus.fill_tag), 32'(m_base[11:7]));
        if (bus.mem_en) begin
          req_q.push_back('{addr: bus.mem_addr, due: cyc + lat});
          n_memen++;
        end
        if (bus.write_data_array) n_dataw++;
        if (bus.write_tag_array)  n_tagw++;
        // advance the model with this cycle's inputs
        m_pw = 0;
        if (m_busy && !e_tag && bus.mem_data_valid && m_ret < 8) begin
          m_pw = 1; m_pw_idx = m_ret; m_ret++;
        end
        if (e_tag) m_busy = 0;
        else if (!m_busy && bus.miss_detected) begin
          m_busy = 1; m_acc = cyc; m_base = bus.miss_address[15:4]; m_ret = 0;
        end
      end
    end
  end

  task automatic step(input logic miss, input logic [15:0] addr, input bit spur, input bit toggle);
    @(posedge clk); #1;
    bus.miss_detected  = toggle ? (bus.fsm_busy ? 1'($urandom_range(0, 1)) : 1'b0) : miss;
    bus.miss_address   = addr;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = 16'($urandom);
    if (gap_left > 0) gap_left--;
    else if (req_q.size() > 0 && req_q[0].due <= cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = mem_word(req_q[0].addr);
      void'(req_q.pop_front());
      returns_sent++;
      gap_left = $urandom_range(0, gap_max);
    end else if (spur && req_q.size() == 0) begin
      bus.mem_data_valid = 1'b1;
    end
  endtask

  task automatic wait_idle(input logic hold_miss, input logic [15:0] hold_addr, input bit toggle);
    for (int i = 0; i < 200; i++) begin
      step(hold_miss, hold_addr, 0, toggle);
      if (!bus.fsm_busy) break;
    end
    chk("fill_done", 32'(bus.fsm_busy), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_q.delete();
    gap_left = 0;
    bus.miss_detected = 1'b0; bus.mem_data_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, d0, t0, m0, rs, tsum;
    logic [15:0] a;
    rst_n = 1'b1;
    bus.miss_detected = 1'b0; bus.miss_address = '0;
    bus.mem_data_valid = 1'b0; bus.mem_data_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // quiet idle: no requests
    m0 = n_memen;
    repeat (10) step(0, 16'h0000, 0, 0);
    chk("idle_no_mem_en", 32'(n_memen - m0), 32'd0);

    // basic fill, L=4, no gaps
    lat = 4; gap_max = 0;
    step(1, 16'hA5B6, 0, 0); c0 = cyc;
    wait_idle(0, 16'h0000, 0);
    step(0, 16'h0000, 0, 0);
    chk("lit_addr_c1",  32'(snap_addr[(c0+1)%8192]), 32'h0000A5B0);
    chk("lit_addr_c8",  32'(snap_addr[(c0+8)%8192]), 32'h0000A5BE);
    chk("lit_memen_c9", 32'(snap_memen[(c0+9)%8192]), 32'd0);
    chk("lit_index",    32'(snap_idx[(c0+3)%8192]), 32'h5B);
    chk("lit_tag",      32'(snap_tag[(c0+3)%8192]), 32'h14);
    chk("lit_wen_c5",   32'(snap_wen[(c0+5)%8192]), 32'h00);
    chk("lit_wen_c6",   32'(snap_wen[(c0+6)%8192]), 32'h01);
    chk("lit_wen_c13",  32'(snap_wen[(c0+13)%8192]), 32'h80);
    chk("lit_tagw_c12", 32'(snap_tagw[(c0+12)%8192]), 32'd0);
    chk("lit_tagw_c13", 32'(snap_tagw[(c0+13)%8192]), 32'd1);
    chk("lit_busy_c13", 32'(snap_busy[(c0+13)%8192]), 32'd1);
    chk("lit_busy_c14", 32'(snap_busy[(c0+14)%8192]), 32'd0);

    // mid-sim reset while idle
    do_reset(3);
    step(0, 16'h0000, 0, 0);

    // irregular returns, random latency and gaps
    gap_max = 3;
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 6);
      a = 16'($urandom);
      d0 = n_dataw; t0 = n_tagw;
      step(1, a, 0, 0);
      wait_idle(0, 16'h0000, 0);
      step(0, 16'h0000, 0, 0);
      chk("irr_words", 32'(n_dataw - d0), 32'd8);
      chk("irr_tagw",  32'(n_tagw - t0), 32'd1);
    end

    // spurious valids in IDLE and miss toggling during FILL
    lat = 4; gap_max = 0;
    d0 = n_dataw;
    repeat (5) step(0, 16'($urandom), 1, 0);
    chk("spur_no_write", 32'(n_dataw - d0), 32'd0);
    t0 = n_tagw;
    step(1, 16'h3C48, 1, 0); c0 = cyc;
    wait_idle(0, 16'h9999, 1);
    step(0, 16'h0000, 0, 0);
    chk("spur_index", 32'(snap_idx[(c0+10)%8192]), 32'h44);
    chk("spur_tag",   32'(snap_tag[(c0+10)%8192]), 32'h07);
    chk("spur_tagw",  32'(n_tagw - t0), 32'd1);

    // reset abort after the 3rd return
    gap_max = 2;
    step(1, 16'h7E32, 0, 0); rs = returns_sent;
    for (int i = 0; i < 100; i++) begin
      step(0, 16'h0000, 0, 0);
      if (returns_sent - rs >= 3) break;
    end
    chk("abort_reached", 32'(returns_sent - rs), 32'd3);
    t0 = n_tagw;
    do_reset(2);
    repeat (5) step(0, 16'h0000, 0, 0);
    chk("abort_no_tag", 32'(n_tagw - t0), 32'd0);
    d0 = n_dataw;
    step(1, 16'h4D2A, 0, 0);
    wait_idle(0, 16'h0000, 0);
    step(0, 16'h0000, 0, 0);
    chk("after_abort_words", 32'(n_dataw - d0), 32'd8);
    chk("after_abort_tagw",  32'(n_tagw - t0), 32'd1);

    // back-to-back: miss held high, new address accepted in the first IDLE cycle
    gap_max = 0; lat = 4;
    t0 = n_tagw;
    step(1, 16'h1234, 0, 0); c0 = cyc;
    wait_idle(1, 16'hBEEF, 0);
    wait_idle(0, 16'h0000, 0);
    step(0, 16'h0000, 0, 0);
    tsum = 0;
    for (int i = 0; i <= 14; i++) tsum += int'(snap_tagw[(c0+i)%8192]);
    chk("b2b_first_tag_once", 32'(tsum), 32'd1);
    chk("b2b_idle_c14",  32'(snap_busy[(c0+14)%8192]), 32'd0);
    chk("b2b_busy_c15",  32'(snap_busy[(c0+15)%8192]), 32'd1);
    chk("b2b_addr_c15",  32'(snap_addr[(c0+15)%8192]), 32'h0000BEE0);
    chk("b2b_index_1",   32'(snap_idx[(c0+3)%8192]), 32'h23);
    chk("b2b_index_2",   32'(snap_idx[(c0+20)%8192]), 32'h6E);
    chk("b2b_tagw",      32'(n_tagw - t0), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
